md5_block_builder: RTL and testbench
====================================

Name: md5_block_builder

Overview:
- Upstream feeder of the 64-step MD5 pipeline (ROUND 0..63 stages, `i_valid` only, no backpressure).
- Takes a secret-key byte stream once, then emits one fully padded 512-bit MD5 block per clock for messages key||decimal(N), N = 1, 2, 3, …
- Tags each block with N so the downstream hash checker can report the winning number.
- N is held as a BCD counter, so no binary-to-decimal divider is needed.

Parameters:
- KEY_MAX_BYTES, 16, maximum key length in bytes; KEY_MAX_BYTES + DIGITS_MAX <= 55 is enforced by elaboration assertion.
- DIGITS_MAX, 10, maximum decimal digits of N.
- NUM_BITS, 32, width of the binary tag `o_number`.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- key_valid  input  1  key byte strobe
- key_byte  input  8  key byte (ASCII)
- key_last  input  1  marks final key byte (qualified by `key_valid`)
- start  input  1  begin emission (pulse)
- stop  input  1  downstream match found; halt emission (pulse)
- o_valid  output  1  block valid
- o_block  output  512  word i at bits [32i+31:32i], i = 0..15
- o_number  output  NUM_BITS  binary value of N for this block
- busy  output  1  high in RUN
- key_err  output  1  sticky: key byte dropped (exceeded KEY_MAX_BYTES)
- ovf  output  1  sticky: DIGITS_MAX range exhausted

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0 (`o_block` = 0). State goes to IDLE. Key length L = 0, BCD counter = 1, digit count D = 1.
- States:
  - IDLE: `key_valid` stores the byte at index L and sets L++. Goes to LOAD unless `key_last` is also set.
  - LOAD: accepts bytes the same way. `key_last` returns to IDLE with the key frozen.
  - `start` in IDLE goes to RUN. `start` in LOAD is ignored. L = 0 is legal.
  - RUN: every cycle registers `o_valid` = 1, the block for the current N, and `o_number` = N. Then increments the BCD counter and `o_number`.
  - DONE: `o_valid` = 0. Only reset or a new key load (goes to LOAD, L restarts at 0, counter reset to 1) leaves DONE.
- Latency: `start` sampled at edge k gives the first block (N = 1) valid after edge k+1. Blocks follow back-to-back with no gaps.
- Block layout, M = L + D message bytes:
  - byte j sits in word j/4, bits 8*(j%4)+7 : 8*(j%4), little-endian.
  - bytes 0..L-1 = key.
  - bytes L..M-1 = ASCII digits of N, most-significant first, no leading zeros.
  - byte M = 0x80.
  - all other bytes 0, except word 14 = M*8 and word 15 = 0.
- BCD increment:
  - digit carry ripples within one cycle.
  - when all D digits are 9, the next value is 1 followed by D zeros, and D increments.
  - if D = DIGITS_MAX and all digits are 9: that block is emitted, `ovf` is set, state goes to DONE.
- `stop` in RUN: the block registered on that same edge is suppressed (`o_valid` = 0 after that edge). State goes to DONE. `o_number` holds its last value.
- `stop` and `start` together in IDLE: `stop` wins and the state stays IDLE.
- `stop` outside RUN is ignored.
- Key bytes beyond KEY_MAX_BYTES are dropped and set `key_err`. L saturates and `key_last` still terminates the load.
- `key_valid` in RUN is ignored.
- Reset mid-RUN: `o_valid` drops immediately (asynchronous). The key is lost.
- `o_number` wraps modulo 2^NUM_BITS. This has no effect on the BCD value.

Optional Feature:
- Macro: MD5_BLOCK_BUILDER_STRIDE_EN.
- Defined: adds parameters LANE_ID (default 0) and LANES (default 1, 1..9). The counter starts at LANE_ID+1 and increments by LANES per block using a BCD add of a single-digit constant. `o_number` increments by LANES. This lets parallel pipelines cover disjoint N sets.
- Undefined: start is 1 and step is 1; the parameters are absent.

Test Plan:
- Key "abcdef", start → first block: word0 = 0x64636261, word1 = 0x80316665, words 2–13 = 0, word14 = 0x00000038, `o_number` = 1.
- Same run, cycle 10 (N = 10) → word1 = 0x30316665, word2 = 0x00000080, word14 = 0x40. Checks the 9→10 rollover and D = 2.
- Run to N = 609043 → word1 = 0x30366665, word2 = 0x33343039, word3 = 0x00000080, word14 = 0x60. Then `stop` → `o_valid` low on the following cycle, no block for N = 609044, `busy` = 0.
- L = 0 key (`key_last` on first byte excluded, i.e. start with no load) → word0 = 0x00008031, word14 = 0x08. Also 17-byte key with KEY_MAX_BYTES = 16 → `key_err` = 1, L = 16.
- DIGITS_MAX = 2 → N = 99 emitted, then `ovf` = 1, DONE, `o_valid` = 0.
- Assert reset mid-RUN → `o_valid`, `busy`, `o_block` = 0 with no clock edge. A fresh key load plus start restarts at N = 1.

Source files
------------

// File: rtl/md5_block_builder.sv
// MD5 message-block feeder: loads a key once, then streams padded blocks for key||decimal(N), N = 1, 2, ...
// Optional macro MD5_BLOCK_BUILDER_STRIDE_EN adds LANE_ID/LANES so parallel copies cover disjoint N sets.
// Output handshake: o_valid alone qualifies o_block/o_number for one cycle; there is no ready, the consumer must accept every valid beat.
module md5_block_builder #(
  parameter int KEY_MAX_BYTES = 16,
  parameter int DIGITS_MAX    = 10,
  parameter int NUM_BITS      = 32
`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
  ,
  parameter int LANE_ID       = 0,
  parameter int LANES         = 1
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [7:0]          key_byte,
  input  logic                key_last,
  input  logic                start,
  input  logic                stop,
  output logic                o_valid,
  output logic [511:0]        o_block,
  output logic [NUM_BITS-1:0] o_number,
  output logic                busy,
  output logic                key_err,
  output logic                ovf,
  output logic [1:0]          dbg_state_o
);

  localparam int LW = $clog2(KEY_MAX_BYTES + 1);
  localparam int DW = $clog2(DIGITS_MAX + 1);

`ifdef MD5_BLOCK_BUILDER_STRIDE_EN
  localparam logic [3:0] INIT_DIGIT = 4'(LANE_ID + 1);
  localparam logic [3:0] STEP_DIGIT = 4'(LANES);
  if (LANES < 1 || LANES > 9) begin : g_lanes_chk
    $error("md5_block_builder: LANES must be 1..9");
  end
  if (LANE_ID < 0 || LANE_ID >= LANES) begin : g_lane_id_chk
    $error("md5_block_builder: LANE_ID must be 0..LANES-1");
  end
`else
  localparam logic [3:0] INIT_DIGIT = 4'd1;
  localparam logic [3:0] STEP_DIGIT = 4'd1;
`endif

  if (KEY_MAX_BYTES + DIGITS_MAX > 55) begin : g_size_chk
    $error("md5_block_builder: KEY_MAX_BYTES + DIGITS_MAX must not exceed 55");
  end
  if (NUM_BITS < 4) begin : g_num_chk
    $error("md5_block_builder: NUM_BITS must be at least 4");
  end

  localparam logic [DIGITS_MAX*4-1:0] BCD_INIT = {{(DIGITS_MAX*4-4){1'b0}}, INIT_DIGIT};
  localparam logic [NUM_BITS-1:0]     NUM_INIT = {{(NUM_BITS-4){1'b0}}, INIT_DIGIT};
  localparam logic [NUM_BITS-1:0]     NUM_STEP = {{(NUM_BITS-4){1'b0}}, STEP_DIGIT};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                             state_q;
  logic [KEY_MAX_BYTES-1:0][7:0]      key_q;
  logic [LW-1:0]                      len_q;
  logic [DIGITS_MAX-1:0][3:0]         bcd_q;
  logic [DW-1:0]                      dcnt_q;
  logic [NUM_BITS-1:0]                num_q;
  logic                               o_valid_q;
  logic [511:0]                       o_block_q;
  logic [NUM_BITS-1:0]                o_number_q;
  logic                               key_err_q;
  logic                               ovf_q;

  logic [DIGITS_MAX-1:0][3:0]         bcd_d;
  logic [DW-1:0]                      dcnt_d;
  logic                               bcd_ovf;
  logic [4:0]                         dsum;
  logic [3:0]                         carry;

  logic [55:0][7:0]                   bytes_d;
  logic [5:0]                         len_w;
  logic [5:0]                         dcnt_w;
  logic [5:0]                         m_w;
  logic [5:0]                         pos;
  logic [511:0]                       block_d;

  logic [LW-1:0]                      load_idx;
  logic                               load_en;

  // Single-digit step added at digit 0; carries ripple through every digit in one cycle.
  always_comb begin
    bcd_d  = bcd_q;
    dcnt_d = dcnt_q;
    carry  = STEP_DIGIT;
    dsum   = 5'd0;
    for (int i = 0; i < DIGITS_MAX; i++) begin
      dsum = {1'b0, bcd_q[i]} + {1'b0, carry};
      if (dsum >= 5'd10) begin
        bcd_d[i] = 4'(dsum - 5'd10);
        carry    = 4'd1;
      end else begin
        bcd_d[i] = dsum[3:0];
        carry    = 4'd0;
      end
      if (bcd_d[i] != 4'd0) begin
        dcnt_d = DW'(i + 1);
      end
    end
    bcd_ovf = (carry != 4'd0);
  end

  // Little-endian byte j lands in bits [8j+7:8j]; M = L + D never exceeds 55.
  always_comb begin
    bytes_d = '0;
    len_w   = 6'(len_q);
    dcnt_w  = 6'(dcnt_q);
    m_w     = len_w + dcnt_w;
    pos     = 6'd0;
    for (int j = 0; j < KEY_MAX_BYTES; j++) begin
      if (6'(j) < len_w) begin
        bytes_d[j] = key_q[j];
      end
    end
    for (int k = 0; k < DIGITS_MAX; k++) begin
      pos = m_w - 6'd1 - 6'(k);
      if (6'(k) < dcnt_w) begin
        bytes_d[pos] = {4'h3, bcd_q[k]};
      end
    end
    bytes_d[m_w] = 8'h80;
    block_d = {32'd0, 23'd0, m_w, 3'd0, bytes_d};
  end

  // A key byte arriving in DONE starts a fresh key at index 0.
  assign load_en  = key_valid && (state_q != S_RUN);
  assign load_idx = (state_q == S_DONE) ? '0 : len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      len_q      <= '0;
      bcd_q      <= BCD_INIT;
      dcnt_q     <= DW'(1);
      num_q      <= NUM_INIT;
      o_valid_q  <= 1'b0;
      o_block_q  <= '0;
      o_number_q <= '0;
      key_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (load_en) begin
        if (load_idx < LW'(KEY_MAX_BYTES)) begin
          for (int j = 0; j < KEY_MAX_BYTES; j++) begin
            if (load_idx == LW'(j)) begin
              key_q[j] <= key_byte;
            end
          end
          len_q <= load_idx + LW'(1);
        end else begin
          len_q     <= load_idx;
          key_err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            state_q <= key_last ? S_IDLE : S_LOAD;
          end else if (start && !stop) begin
            state_q <= S_RUN;
          end
        end
        S_LOAD: begin
          if (key_valid && key_last) begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (stop) begin
            o_valid_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            o_valid_q  <= 1'b1;
            o_block_q  <= block_d;
            o_number_q <= num_q;
            num_q      <= num_q + NUM_STEP;
            bcd_q      <= bcd_d;
            dcnt_q     <= dcnt_d;
            if (bcd_ovf) begin
              ovf_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          o_valid_q <= 1'b0;
          if (key_valid) begin
            bcd_q   <= BCD_INIT;
            dcnt_q  <= DW'(1);
            num_q   <= NUM_INIT;
            state_q <= key_last ? S_IDLE : S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_valid     = o_valid_q;
  assign o_block     = o_block_q;
  assign o_number    = o_number_q;
  assign busy        = (state_q == S_RUN);
  assign key_err     = key_err_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md5_block_builder.sv
// Bench for md5_block_builder: a reference model built from $sformatf decimal strings fills an expected queue
// that is drained against each valid block; a second instance with DIGITS_MAX = 2 covers digit overflow.
module tb_md5_block_builder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [7:0]   key_byte = 8'h00;
  logic         key_last = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;

  logic         o_valid, busy, key_err, ovf;
  logic [511:0] o_block;
  logic [31:0]  o_number;
  logic [1:0]   dbg_state;

  logic         d2_valid, d2_busy, d2_key_err, d2_ovf;
  logic [511:0] d2_block;
  logic [31:0]  d2_number;
  logic [1:0]   d2_state;

  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [543:0] exp_q[$];
  logic [543:0] want;
  logic [7:0]   tb_key [16];
  int           tb_len = 0;

  md5_block_builder u_dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_byte(key_byte), .key_last(key_last),
    .start(start), .stop(stop), .o_valid(o_valid), .o_block(o_block), .o_number(o_number),
    .busy(busy), .key_err(key_err), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  md5_block_builder #(.DIGITS_MAX(2)) u_dut2 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_byte(key_byte), .key_last(key_last),
    .start(start), .stop(stop), .o_valid(d2_valid), .o_block(d2_block), .o_number(d2_number),
    .busy(d2_busy), .key_err(d2_key_err), .ovf(d2_ovf), .dbg_state_o(d2_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] model_block(input int n);
    logic [7:0]   b [64];
    string        s;
    int           m;
    logic [511:0] r;
    s = $sformatf("%0d", n);
    foreach (b[i]) b[i] = 8'h00;
    for (int i = 0; i < tb_len; i++) b[i] = tb_key[i];
    for (int i = 0; i < s.len(); i++) b[tb_len + i] = s[i];
    m = tb_len + s.len();
    b[m] = 8'h80;
    r = '0;
    for (int i = 0; i < 56; i++) r[8*i +: 8] = b[i];
    r[448 +: 32] = 32'(m * 8);
    return r;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_key(input string s);
    tb_len = (s.len() > 16) ? 16 : s.len();
    for (int i = 0; i < tb_len; i++) tb_key[i] = s[i];
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key_byte  = s[i];
      key_last  = (i == s.len() - 1);
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int n = first; n <= last; n++) exp_q.push_back({32'(n), model_block(n)});
  endtask

  // scenarios
  task automatic test_reset();
    vec_cnt++;
    if ({o_valid, busy, key_err, ovf, dbg_state} !== 6'b0 || o_block !== '0 || o_number !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: valid=%b busy=%b kerr=%b ovf=%b st=%0d num=%0d blk_nz=%b, want all zero",
               o_valid, busy, key_err, ovf, dbg_state, o_number, |o_block);
    end
    vec_cnt++;
    if ({d2_valid, d2_busy, d2_ovf} !== 3'b0 || d2_block !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs_d2: valid=%b busy=%b ovf=%b, want 0", d2_valid, d2_busy, d2_ovf);
    end
  endtask

  task automatic test_run_stop();
    set_key("abcdef");
    push_range(1, 1234);
    pulse_start();
    vec_cnt++;
    if (busy !== 1'b1 || o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_latency: busy=%b valid=%b, want busy=1 valid=0", busy, o_valid);
    end
    for (int i = 1; i <= 1234; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL run_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, o_valid, o_number, o_block, want[543:512], want[511:0]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (o_block[63:0] !== 64'h80316665_64636261 || o_block[479:448] !== 32'h38 || o_block[447:64] !== '0) begin
          err_cnt++;
          $display("FAIL first_block_words: w1w0=%h w14=%h, want 8031666564636261 00000038", o_block[63:0], o_block[479:448]);
        end
      end
      if (i == 10) begin
        vec_cnt++;
        if (o_block[95:32] !== 64'h00000080_30316665 || o_block[479:448] !== 32'h40) begin
          err_cnt++;
          $display("FAIL n10_words: w2w1=%h w14=%h, want 0000008030316665 00000040", o_block[95:32], o_block[479:448]);
        end
      end
      if (i == 1234) begin
        vec_cnt++;
        if (o_block[95:32] !== 64'h00803433_32316665 || o_block[479:448] !== 32'h50) begin
          err_cnt++;
          $display("FAIL n1234_words: w2w1=%h w14=%h, want 0080343332316665 00000050", o_block[95:32], o_block[479:448]);
        end
      end
    end
    pulse_stop();
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (o_valid !== 1'b0 || busy !== 1'b0 || o_number !== 32'd1234) begin
        err_cnt++;
        $display("FAIL after_stop c%0d: valid=%b busy=%b num=%0d, want 0 0 1234", i, o_valid, busy, o_number);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reload_from_done();
    set_key("xy");
    vec_cnt++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reload_idle: state=%0d busy=%b, want 0 0", dbg_state, busy);
    end
    push_range(1, 3);
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL reload_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, o_valid, o_number, o_block, want[543:512], want[511:0]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (o_block[31:0] !== 32'h80317978) begin
          err_cnt++;
          $display("FAIL reload_word0: got %h, want 80317978", o_block[31:0]);
        end
      end
    end
    pulse_stop();
  endtask

  task automatic test_empty_key();
    do_reset();
    tb_len = 0;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    vec_cnt++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL stop_beats_start: busy=%b state=%0d, want 0 0", busy, dbg_state);
    end
    @(negedge clk);
    vec_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stop_beats_start_valid: valid=%b, want 0", o_valid);
    end
    push_range(1, 12);
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL empty_key_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, o_valid, o_number, o_block, want[543:512], want[511:0]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (o_block[31:0] !== 32'h00008031 || o_block[479:448] !== 32'h08) begin
          err_cnt++;
          $display("FAIL empty_key_words: w0=%h w14=%h, want 00008031 00000008", o_block[31:0], o_block[479:448]);
        end
      end
    end
    pulse_stop();
    vec_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL empty_key_stop: valid=%b, want 0", o_valid);
    end
  endtask

  task automatic test_key_overflow();
    do_reset();
    set_key("ABCDEFGHIJKLMNOPQ");
    vec_cnt++;
    if (key_err !== 1'b1 || dbg_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL key_err_flag: key_err=%b state=%0d, want 1 0", key_err, dbg_state);
    end
    push_range(1, 3);
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL long_key_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, o_valid, o_number, o_block, want[543:512], want[511:0]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (o_block[159:128] !== 32'h00008031 || o_block[479:448] !== 32'h88) begin
          err_cnt++;
          $display("FAIL long_key_words: w4=%h w14=%h, want 00008031 00000088", o_block[159:128], o_block[479:448]);
        end
      end
    end
    pulse_stop();
  endtask

  task automatic test_ovf();
    do_reset();
    set_key("abc");
    push_range(1, 99);
    pulse_start();
    for (int i = 1; i <= 99; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (d2_valid !== 1'b1 || {d2_number, d2_block} !== want) begin
        err_cnt++;
        $display("FAIL d2_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, d2_valid, d2_number, d2_block, want[543:512], want[511:0]);
      end
      if (i == 98) begin
        vec_cnt++;
        if (d2_ovf !== 1'b0 || d2_busy !== 1'b1) begin
          err_cnt++;
          $display("FAIL d2_pre_ovf: ovf=%b busy=%b, want 0 1", d2_ovf, d2_busy);
        end
      end
      if (i == 99) begin
        vec_cnt++;
        if (d2_ovf !== 1'b1 || d2_busy !== 1'b0 || d2_state !== 2'd3) begin
          err_cnt++;
          $display("FAIL d2_ovf_set: ovf=%b busy=%b state=%0d, want 1 0 3", d2_ovf, d2_busy, d2_state);
        end
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (d2_valid !== 1'b0 || d2_ovf !== 1'b1 || d2_number !== 32'd99) begin
      err_cnt++;
      $display("FAIL d2_after_ovf: valid=%b ovf=%b num=%0d, want 0 1 99", d2_valid, d2_ovf, d2_number);
    end
    vec_cnt++;
    if (ovf !== 1'b0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL main_no_ovf: ovf=%b busy=%b, want 0 1", ovf, busy);
    end
    pulse_stop();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_key("md5");
    push_range(1, 5);
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL pre_reset_block n=%0d: valid=%b num=%0d, want num=%0d", i, o_valid, o_number, want[543:512]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || o_block !== '0 || o_number !== 32'd0) begin
      err_cnt++;
      $display("FAIL async_reset: valid=%b busy=%b blk_nz=%b num=%0d, want all 0", o_valid, busy, |o_block, o_number);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    set_key("ok");
    push_range(1, 2);
    pulse_start();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      vec_cnt++;
      if (o_valid !== 1'b1 || {o_number, o_block} !== want) begin
        err_cnt++;
        $display("FAIL restart_block n=%0d: valid=%b num=%0d blk=%h, want num=%0d blk=%h",
                 i, o_valid, o_number, o_block, want[543:512], want[511:0]);
      end
    end
    pulse_stop();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_run_stop();
    test_reload_from_done();
    test_empty_key();
    test_key_overflow();
    test_ovf();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
